uart_word_tx: RTL and testbench

//  Transmit-side counterpart of the UART command path: frames 32-bit readback/status

---
 rtl/uart_word_tx_pkg.sv | 35 +++
 rtl/uart_word_tx_if.sv | 27 ++
 rtl/uart_word_tx.sv | 155 +++++++++++++++
 tb/tb_uart_word_tx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_word_tx_pkg.sv
// Shared definitions for the UART word transmitter: frame constants, FSM state
// encoding and a byte-select helper used when serialising payload words.
package uart_word_tx_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         BYTES_PER_WORD    = 4;
    // Frame bytes that are not payload: SYNC, LEN and the checksum.
    localparam int         FRAME_OVERHEAD    = 3;
    localparam logic [1:0] FIRST_BYTE_IDX    = 2'd3;
    localparam logic [1:0] LAST_BYTE_IDX     = 2'd0;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SYNC      = 3'd1,
        LEN       = 3'd2,
        WAIT_WORD = 3'd3,
        BYTE      = 3'd4,
        CSUM      = 3'd5,
        DONE      = 3'd6
    } tx_state_t;

    // Byte idx of a word, idx 3 being the most significant byte.
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd3:    b = w[31:24];
            2'd2:    b = w[23:16];
            2'd1:    b = w[15:8];
            2'd0:    b = w[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_word_tx_if.sv
// Word-source and TX-queue signals of the UART word transmitter, bundled with
// a slave view for the transmitter and a master view for its environment.
interface uart_word_tx_if #(
    parameter int LEN_WIDTH = 6
);
    logic                 i_start;
    logic [LEN_WIDTH-1:0] i_len;
    logic                 o_busy;
    logic                 o_err;
    logic                 o_done;
    logic [31:0]          i_word;
    logic                 i_word_valid;
    logic                 o_word_ready;
    logic                 o_enq_txq;
    logic [7:0]           o_txq_data;
    logic                 i_txq_full;

    modport slave (
        input  i_start, i_len, i_word, i_word_valid, i_txq_full,
        output o_busy, o_err, o_done, o_word_ready, o_enq_txq, o_txq_data
    );

    modport master (
        output i_start, i_len, i_word, i_word_valid, i_txq_full,
        input  o_busy, o_err, o_done, o_word_ready, o_enq_txq, o_txq_data
    );
endinterface

// File: rtl/uart_word_tx.sv
// Frames 32-bit words as SYNC, LEN, payload (MSB byte first), XOR checksum and
// pushes the bytes into the UART TX FIFO, stalling while the FIFO is full.
module uart_word_tx
    import uart_word_tx_pkg::*;
#(
    parameter int         MAX_WORDS = 32,
    parameter int         LEN_WIDTH = $clog2(MAX_WORDS + 1),
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic          i_clk,
    input  logic          i_rst,
    uart_word_tx_if.slave bus
);

    tx_state_t            r_state;
    logic [LEN_WIDTH-1:0] r_len;
    logic [LEN_WIDTH-1:0] r_remaining;
    logic [31:0]          r_word;
    logic [1:0]           r_idx;
    logic [7:0]           r_csum;
    logic [7:0]           r_txq_data;
    logic                 r_busy;
    logic                 r_err;
    logic                 r_done;
    logic                 r_word_ready;

    logic                 w_emitting;
    logic                 w_enq;
    logic                 w_handshake;
    logic                 w_len_ok;
    logic [7:0]           w_csum_next;

    // Decode which states drive a byte towards the TX FIFO.
    always_comb begin
        w_emitting = 1'b0;
        case (r_state)
            SYNC, LEN, BYTE, CSUM: w_emitting = 1'b1;
            default:               w_emitting = 1'b0;
        endcase
    end

    // The enqueue strobe must react to full in the same cycle, so it stays combinational.
    assign w_enq       = w_emitting && !bus.i_txq_full;
    assign w_handshake = r_word_ready && bus.i_word_valid;
    assign w_len_ok    = (bus.i_len != {LEN_WIDTH{1'b0}}) && (32'(bus.i_len) <= 32'(MAX_WORDS));
    assign w_csum_next = r_csum ^ r_txq_data;

    // Frame sequencer: the byte on o_txq_data is loaded one state ahead of its emission.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_len        <= {LEN_WIDTH{1'b0}};
            r_remaining  <= {LEN_WIDTH{1'b0}};
            r_word       <= 32'h0000_0000;
            r_idx        <= 2'd0;
            r_csum       <= 8'h00;
            r_txq_data   <= 8'h00;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
            r_done       <= 1'b0;
            r_word_ready <= 1'b0;
        end else begin
            r_err  <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.i_start && w_len_ok) begin
                        r_len       <= bus.i_len;
                        r_remaining <= bus.i_len;
                        r_csum      <= 8'h00;
                        r_txq_data  <= SYNC_BYTE;
                        r_busy      <= 1'b1;
                        r_state     <= SYNC;
                    end else if (bus.i_start) begin
                        r_err <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SYNC: begin
                    if (w_enq) begin
                        r_txq_data <= 8'(r_len);
                        r_state    <= LEN;
                    end else begin
                        r_state <= SYNC;
                    end
                end
                LEN: begin
                    if (w_enq) begin
                        r_csum       <= w_csum_next;
                        r_word_ready <= 1'b1;
                        r_state      <= WAIT_WORD;
                    end else begin
                        r_state <= LEN;
                    end
                end
                WAIT_WORD: begin
                    if (w_handshake) begin
                        r_word       <= bus.i_word;
                        r_remaining  <= r_remaining - LEN_WIDTH'(1);
                        r_idx        <= FIRST_BYTE_IDX;
                        r_txq_data   <= word_byte(bus.i_word, FIRST_BYTE_IDX);
                        r_word_ready <= 1'b0;
                        r_state      <= BYTE;
                    end else begin
                        r_state <= WAIT_WORD;
                    end
                end
                BYTE: begin
                    if (w_enq) begin
                        r_csum <= w_csum_next;
                        if (r_idx != LAST_BYTE_IDX) begin
                            r_idx      <= r_idx - 2'd1;
                            r_txq_data <= word_byte(r_word, r_idx - 2'd1);
                        end else if (r_remaining != {LEN_WIDTH{1'b0}}) begin
                            r_word_ready <= 1'b1;
                            r_state      <= WAIT_WORD;
                        end else begin
                            // Checksum already includes the byte leaving this cycle.
                            r_txq_data <= w_csum_next;
                            r_state    <= CSUM;
                        end
                    end else begin
                        r_state <= BYTE;
                    end
                end
                CSUM: begin
                    if (w_enq) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_state <= CSUM;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state      <= IDLE;
                    r_busy       <= 1'b0;
                    r_word_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_busy       = r_busy;
    assign bus.o_err        = r_err;
    assign bus.o_done       = r_done;
    assign bus.o_word_ready = r_word_ready;
    assign bus.o_enq_txq    = w_enq;
    assign bus.o_txq_data   = r_txq_data;

endmodule

// File: tb/tb_uart_word_tx.sv
// Scoreboard bench for uart_word_tx: directed frames push expected bytes, a
// negedge monitor pops and compares every byte the DUT enqueues.
module tb_uart_word_tx;

    localparam int MAX_WORDS = 32;
    localparam int LEN_W     = 6;

    logic clk;
    logic rst;

    uart_word_tx_if #(.LEN_WIDTH(LEN_W)) bus ();

    uart_word_tx #(.MAX_WORDS(MAX_WORDS)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  exp_q [$];
    logic [31:0] word_q[$];
    int n_checks  = 0;
    int n_pass    = 0;
    int mon_bytes = 0;
    int done_cnt  = 0;
    int err_cnt   = 0;
    bit rand_full = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every enqueued byte must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_enq_txq) begin
                mon_bytes++;
                check("enq_while_full", 32'(bus.i_txq_full), 32'd0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_byte: got %h expected none at %0t", bus.o_txq_data, $time);
                end else begin
                    check("txq_byte", 32'(bus.o_txq_data), 32'(exp_q.pop_front()));
                end
            end
            if (bus.o_done) begin
                done_cnt++;
                check("done_busy_low", 32'(bus.o_busy), 32'd0);
            end
            if (bus.o_err) err_cnt++;
        end
    end

    // Word source: presents the head of word_q whenever it is non-empty.
    always @(posedge clk) begin
        bit hs;
        hs = bus.i_word_valid && bus.o_word_ready;
        #1;
        if (hs && word_q.size() > 0) void'(word_q.pop_front());
        bus.i_word_valid = (word_q.size() > 0);
        bus.i_word       = (word_q.size() > 0) ? word_q[0] : 32'h0;
    end

    // Pseudo-random FIFO back-pressure for the long frame.
    always @(posedge clk) begin
        #1;
        if (rand_full) bus.i_txq_full = ($urandom_range(0, 2) == 0);
    end

    task automatic pulse_start(input int len);
        @(posedge clk); #1;
        bus.i_start = 1'b1;
        bus.i_len   = LEN_W'(len);
        @(posedge clk); #1;
        bus.i_start = 1'b0;
    endtask

    task automatic push_exp(input logic [7:0] b);
        exp_q.push_back(b);
    endtask

    task automatic wait_done(input int target, input string name);
        int i;
        for (i = 0; i < 4000; i++) begin
            @(negedge clk); #1;
            if (done_cnt >= target) break;
        end
        check(name, 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic wait_bytes(input int target, input string name);
        int i;
        for (i = 0; i < 2000; i++) begin
            if (mon_bytes >= target) break;
            @(negedge clk); #1;
        end
        check(name, 32'(mon_bytes >= target), 32'd1);
    endtask

    initial begin
        logic [7:0]  c;
        logic [31:0] w;
        int base;

        rst = 1'b1;
        bus.i_start = 1'b0;
        bus.i_len = '0;
        bus.i_txq_full = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(bus.o_busy), 32'd0);
        check("rst_enq", 32'(bus.o_enq_txq), 32'd0);
        check("rst_ready", 32'(bus.o_word_ready), 32'd0);
        check("rst_data", 32'(bus.o_txq_data), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single-word frame.
        word_q.push_back(32'h11223344);
        foreach (exp_q[i]) ; // keep scoreboard untouched
        push_exp(8'hA5); push_exp(8'h01); push_exp(8'h11); push_exp(8'h22);
        push_exp(8'h33); push_exp(8'h44); push_exp(8'h45);
        pulse_start(1);
        check("busy_after_start", 32'(bus.o_busy), 32'd1);
        wait_done(1, "t1_done");
        repeat (3) @(posedge clk);
        check("t1_done_once", 32'(done_cnt), 32'd1);

        // Two words, FIFO full for 5 cycles while byte BE is pending.
        word_q.push_back(32'hDEADBEEF); word_q.push_back(32'h00000000);
        push_exp(8'hA5); push_exp(8'h02); push_exp(8'hDE); push_exp(8'hAD);
        push_exp(8'hBE); push_exp(8'hEF); push_exp(8'h00); push_exp(8'h00);
        push_exp(8'h00); push_exp(8'h00); push_exp(8'h20);
        pulse_start(2);
        for (int i = 0; i < 200; i++) begin
            if (bus.o_txq_data == 8'hBE) break;
            @(posedge clk); #1;
        end
        bus.i_txq_full = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("t2_stall_hold", 32'(bus.o_txq_data), 32'hBE);
        bus.i_txq_full = 1'b0;
        wait_done(2, "t2_done");

        // Rejected lengths.
        base = mon_bytes;
        pulse_start(0);
        check("len0_err", 32'(bus.o_err), 32'd1);
        check("len0_busy", 32'(bus.o_busy), 32'd0);
        @(posedge clk); #1;
        check("len0_err_pulse", 32'(bus.o_err), 32'd0);
        pulse_start(MAX_WORDS + 1);
        check("lenmax_err", 32'(bus.o_err), 32'd1);
        check("lenmax_busy", 32'(bus.o_busy), 32'd0);
        repeat (4) @(posedge clk);
        check("err_no_bytes", 32'(mon_bytes), 32'(base));
        check("err_count", 32'(err_cnt), 32'd2);

        // Start pulsed mid-payload must be ignored.
        word_q.push_back(32'h01020304); word_q.push_back(32'hA0B0C0D0);
        push_exp(8'hA5); push_exp(8'h02); push_exp(8'h01); push_exp(8'h02);
        push_exp(8'h03); push_exp(8'h04); push_exp(8'hA0); push_exp(8'hB0);
        push_exp(8'hC0); push_exp(8'hD0); push_exp(8'h06);
        base = mon_bytes;
        pulse_start(2);
        wait_bytes(base + 5, "t4_reach_payload");
        pulse_start(5);
        wait_done(3, "t4_done");
        repeat (10) @(posedge clk);
        check("t4_no_extra", 32'(mon_bytes), 32'(base + 11));
        check("t4_idle", 32'(bus.o_busy), 32'd0);

        // Reset right after the third payload byte.
        word_q.push_back(32'hCAFEF00D); word_q.push_back(32'h12345678);
        push_exp(8'hA5); push_exp(8'h02); push_exp(8'hCA); push_exp(8'hFE); push_exp(8'hF0);
        base = mon_bytes;
        pulse_start(2);
        wait_bytes(base + 5, "t5_reach_third");
        rst = 1'b1;
        word_q.delete();
        @(negedge clk);
        check("t5_rst_busy", 32'(bus.o_busy), 32'd0);
        check("t5_rst_enq", 32'(bus.o_enq_txq), 32'd0);
        check("t5_rst_ready", 32'(bus.o_word_ready), 32'd0);
        check("t5_rst_done", 32'(bus.o_done), 32'd0);
        check("t5_rst_data", 32'(bus.o_txq_data), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        check("t5_aborted", 32'(mon_bytes), 32'(base + 5));
        word_q.push_back(32'h89ABCDEF);
        push_exp(8'hA5); push_exp(8'h01); push_exp(8'h89); push_exp(8'hAB);
        push_exp(8'hCD); push_exp(8'hEF); push_exp(8'h01);
        pulse_start(1);
        wait_done(4, "t5_fresh_done");

        // Maximum-length frame under random back-pressure.
        c = 8'(MAX_WORDS);
        push_exp(8'hA5); push_exp(8'(MAX_WORDS));
        for (int i = 0; i < MAX_WORDS; i++) begin
            w = (32'(i) * 32'h01010101) ^ 32'h5A3C_0F81;
            word_q.push_back(w);
            for (int k = 3; k >= 0; k--) begin
                push_exp(w[8*k +: 8]);
                c = c ^ w[8*k +: 8];
            end
        end
        push_exp(c);
        rand_full = 1'b1;
        pulse_start(MAX_WORDS);
        wait_done(5, "t6_done");
        rand_full = 1'b0;
        bus.i_txq_full = 1'b0;

        repeat (5) @(posedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("done_total", 32'(done_cnt), 32'd5);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
